// File: rtl/ad_sdo_rx_if.sv
// Capture-side link of the ADC serial port: strobe/SDO/CS_n toward the ADC,
// sample word and status toward the core.
interface ad_sdo_rx_if #(parameter int DW = 16);
  logic          pluse;
  logic          start;
  logic          ad_sdo;
  logic          ad_cs_n;
  logic [DW-1:0] data;
  logic          data_vld;
  logic          busy;
  logic [15:0]   sample_cnt;

  modport slave (
    input  pluse, start, ad_sdo,
    output ad_cs_n, data, data_vld, busy, sample_cnt
  );

  modport master (
    output pluse, start, ad_sdo,
    input  ad_cs_n, data, data_vld, busy, sample_cnt
  );
endinterface

// File: rtl/ad_sdo_rx.sv
// Serial ADC receiver: frames a read with ad_cs_n, skips one lead-in strobe,
// then shifts DW bits of SDO in MSB-first and presents the word with a strobe.
module ad_sdo_rx #(
  parameter int DW     = 16,
  parameter int CS_GAP = 2
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  ad_sdo_rx_if.slave bus
);
  localparam int BW = $clog2(DW);
  localparam logic [BW-1:0] LAST     = BW'(DW - 1);
  localparam logic [3:0]    GAP_LAST = 4'(CS_GAP - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          pend_q, pend_d;
  logic [DW-2:0] shift_q, shift_d;
  logic [DW-1:0] data_q, data_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]    gap_cnt_q, gap_cnt_d;
  logic          cs_n_q, cs_n_d;
  logic          vld_q, vld_d;
  logic [15:0]   sample_cnt_q, sample_cnt_d;
  logic [DW-1:0] shift_in;

  // Only DW-1 bits are stored: the final bit goes straight into data.
  assign shift_in = {shift_q, bus.ad_sdo};

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    shift_d      = shift_q;
    data_d       = data_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    cs_n_d       = cs_n_q;
    vld_d        = 1'b0;
    sample_cnt_d = sample_cnt_q;

    // Requests while a frame is in flight collapse into one pending flag.
    if (bus.start && state_q != IDLE) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bus.start || pend_q) begin
          state_d = ARM;
          cs_n_d  = 1'b0;
          pend_d  = 1'b0;
        end
      end
      ARM: begin
        if (bus.pluse) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (bus.pluse) begin
          shift_d   = shift_in[DW-2:0];
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST) begin
            data_d       = shift_in;
            vld_d        = 1'b1;
            sample_cnt_d = sample_cnt_q + 16'd1;
            cs_n_d       = 1'b1;
            gap_cnt_d    = '0;
            bit_cnt_d    = '0;
            state_d      = GAP;
          end
        end
      end
      GAP: begin
        if (bus.pluse) begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_d = '0;
            if (pend_q || bus.start) begin
              state_d = ARM;
              cs_n_d  = 1'b0;
              pend_d  = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      shift_q      <= '0;
      data_q       <= '0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      cs_n_q       <= 1'b1;
      vld_q        <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      cs_n_q       <= cs_n_d;
      vld_q        <= vld_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign bus.ad_cs_n    = cs_n_q;
  assign bus.data       = data_q;
  assign bus.data_vld   = vld_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.sample_cnt = sample_cnt_q;
endmodule

// File: tb/tb_ad_sdo_rx.sv
// Directed bench for ad_sdo_rx: an ADC model feeds SDO from a word queue and a
// scoreboard checks every data_vld against the expected-word queue.
module tb_ad_sdo_rx;
  localparam int DW     = 16;
  localparam int CS_GAP = 2;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  ad_sdo_rx_if #(.DW(DW)) bus();

  ad_sdo_rx #(.DW(DW), .CS_GAP(CS_GAP)) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int            nchk = 0;
  int            nfail = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] adc_q[$];
  logic [15:0]   exp_cnt = 16'd0;
  int            vld_seen = 0;
  bit            pl_en = 1'b1;
  int            ph = 0;

  // ADC model / monitor state
  int            n = 0;
  logic [DW-1:0] cur = '0;
  bit            fin_pend = 1'b0;
  logic          cs_prev = 1'b1;
  logic          busy_prev = 1'b0;
  int            gp = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    nchk++;
    nfail++;
    $error("FAIL %s: timeout waiting for DUT", tag);
  endtask

  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk_sys);
    #2;
  endtask

  task automatic push(input logic [DW-1:0] w, input bit keep);
    adc_q.push_back(w);
    if (keep) begin
      exp_q.push_back(w);
      exp_cnt = exp_cnt + 16'd1;
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int c = 0;
    while (bus.busy !== 1'b0 && c < budget) begin tick(); c++; end
    if (bus.busy !== 1'b0) timeout(tag);
  endtask

  task automatic wait_n(input int target, input int budget, input string tag);
    int c = 0;
    while (n < target && c < budget) begin tick(); c++; end
    if (n < target) timeout(tag);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // sclk strobe: one cycle in four, can be stalled
  always @(posedge clk_sys) begin
    #1;
    if (pl_en) begin
      ph = (ph == 3) ? 0 : ph + 1;
      bus.pluse = (ph == 0);
    end else begin
      bus.pluse = 1'b0;
    end
  end

  always @(negedge clk_sys) begin
    if (bus.data_vld === 1'b1 || fin_pend) begin
      chk("vld_timing", 32'(bus.data_vld), 32'(fin_pend));
      if (bus.data_vld === 1'b1) begin
        vld_seen++;
        if (exp_q.size() == 0) timeout("data_unexpected");
        else chk("data", 32'(bus.data), 32'(exp_q.pop_front()));
      end
    end
    fin_pend = 1'b0;

    if (bus.ad_cs_n && !cs_prev && rst_n) chk("frame_len", 32'(n), 32'(DW + 1));
    if (bus.ad_cs_n && !cs_prev) gp = 0;
    if (!bus.ad_cs_n && cs_prev && busy_prev) chk("gap_b2b", 32'(gp), 32'(CS_GAP));
    if (!bus.busy && busy_prev && rst_n) chk("gap_idle", 32'(gp), 32'(CS_GAP));
    if (bus.pluse && bus.ad_cs_n && bus.busy) gp++;
    cs_prev   = bus.ad_cs_n;
    busy_prev = bus.busy;

    // Lead-in is index 0; index k carries bit DW-k of the word.
    if (bus.ad_cs_n !== 1'b0) begin
      n = 0;
      bus.ad_sdo = 1'b0;
    end else if (bus.pluse) begin
      if (n == 0) begin
        cur = (adc_q.size() != 0) ? adc_q.pop_front() : '0;
        bus.ad_sdo = 1'b0;
      end else if (n <= DW) begin
        bus.ad_sdo = cur[DW-n];
      end
      if (n == DW) fin_pend = 1'b1;
      n++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   v0;
    int   c;
    int   falls;
    logic prev;

    bus.start = 1'b0;
    rst_n = 1'b0;
    tick(3);
    chk("rst_cs_n", 32'(bus.ad_cs_n), 32'd1);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_vld", 32'(bus.data_vld), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cnt", 32'(bus.sample_cnt), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // single frame
    v0 = vld_seen;
    push(16'hA5C3, 1'b1);
    pulse_start();
    chk("single_busy", 32'(bus.busy), 32'd1);
    chk("single_cs_low", 32'(bus.ad_cs_n), 32'd0);
    wait_idle(400, "single_idle");
    chk("single_nvld", 32'(vld_seen - v0), 32'd1);
    chk("single_data", 32'(bus.data), 32'hA5C3);
    chk("single_cnt", 32'(bus.sample_cnt), 32'(exp_cnt));
    chk("single_cs_high", 32'(bus.ad_cs_n), 32'd1);

    // continuous start: three back-to-back frames
    tick(5);
    v0 = vld_seen;
    push(16'h0001, 1'b1);
    push(16'h8000, 1'b1);
    push(16'hFFFF, 1'b1);
    bus.start = 1'b1;
    falls = 0;
    c = 0;
    prev = bus.ad_cs_n;
    while (falls < 3 && c < 1000) begin
      tick();
      if (prev && !bus.ad_cs_n) falls++;
      prev = bus.ad_cs_n;
      c++;
    end
    bus.start = 1'b0;
    if (falls < 3) timeout("cont_falls");
    wait_idle(400, "cont_idle");
    chk("cont_nvld", 32'(vld_seen - v0), 32'd3);
    chk("cont_data", 32'(bus.data), 32'hFFFF);
    chk("cont_cnt", 32'(bus.sample_cnt), 32'(exp_cnt));

    // pending collapse: three starts during SHIFT give one extra frame
    tick(5);
    v0 = vld_seen;
    push(16'h1357, 1'b1);
    push(16'h9BDF, 1'b1);
    pulse_start();
    wait_n(5, 200, "pend_shift");
    repeat (3) begin
      pulse_start();
      tick(3);
    end
    wait_idle(800, "pend_idle");
    chk("pend_nvld", 32'(vld_seen - v0), 32'd2);
    chk("pend_cnt", 32'(bus.sample_cnt), 32'(exp_cnt));
    tick(40);
    chk("pend_stay_idle", 32'(bus.busy), 32'd0);
    chk("pend_no_extra", 32'(vld_seen - v0), 32'd2);

    // reset mid-frame after 7 sampled bits
    v0 = vld_seen;
    push(16'h1234, 1'b0);
    pulse_start();
    wait_n(8, 200, "rst_midframe");
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(bus.ad_cs_n), 32'd1);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_data", 32'(bus.data), 32'd0);
    chk("abort_vld", 32'(bus.data_vld), 32'd0);
    chk("abort_cnt", 32'(bus.sample_cnt), 32'd0);
    exp_cnt = 16'd0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("abort_nvld", 32'(vld_seen - v0), 32'd0);
    push(16'h5A3C, 1'b1);
    pulse_start();
    wait_idle(400, "after_rst_idle");
    chk("after_rst_data", 32'(bus.data), 32'h5A3C);
    chk("after_rst_cnt", 32'(bus.sample_cnt), 32'(exp_cnt));

    // stalled strobe in SHIFT after 5 sampled bits
    tick(5);
    push(16'hC0DE, 1'b1);
    pulse_start();
    wait_n(6, 200, "stall_shift");
    pl_en = 1'b0;
    tick(100);
    chk("stall_state", 32'(dut.state_q), 32'd2);
    chk("stall_bitcnt", 32'(dut.bit_cnt_q), 32'd5);
    chk("stall_cs_n", 32'(bus.ad_cs_n), 32'd0);
    chk("stall_busy", 32'(bus.busy), 32'd1);
    pl_en = 1'b1;
    wait_idle(400, "stall_idle");
    chk("stall_data", 32'(bus.data), 32'hC0DE);
    chk("stall_cnt", 32'(bus.sample_cnt), 32'(exp_cnt));

    // counter wrap
    tick(5);
    force dut.sample_cnt_q = 16'hFFFF;
    tick(2);
    release dut.sample_cnt_q;
    tick();
    chk("wrap_preset", 32'(bus.sample_cnt), 32'hFFFF);
    exp_cnt = 16'hFFFF;
    v0 = vld_seen;
    push(16'h0F0F, 1'b1);
    pulse_start();
    wait_idle(400, "wrap_idle");
    chk("wrap_cnt", 32'(bus.sample_cnt), 32'h0000);
    chk("wrap_nvld", 32'(vld_seen - v0), 32'd1);

    tick(5);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
endmodule
